// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned N_REQ   = 2;
    localparam int unsigned REQ_CPU = 0;
    localparam int unsigned REQ_DMA = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    // One-hot grant vector for a requester index.
    function automatic logic [N_REQ-1:0] sel_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side handshake bundle between the CPU/DMA requesters and the arbiter.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] lock;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] ack;
    logic             busy;
    logic             owner;

    modport master (output req, output lock, input gnt, input ack, input busy, input owner);
    modport slave  (input req, input lock, output gnt, output ack, output busy, output owner);

endinterface

// File: rtl/mem_bus_arbiter_ws_counter.sv
// Loadable wait-state down-counter; holds at zero and clears asynchronously.
module ws_counter #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned LOAD_VAL = 2
) (
    input  logic             cp,
    input  logic             n_mr,
    input  logic             load,
    input  logic             en,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    always_ff @(posedge cp or negedge n_mr) begin
        if (!n_mr) begin
            value <= '0;
        end else if (load) begin
            value <= CNT_W'(LOAD_VAL);
        end else if (en && (value != '0)) begin
            value <= value - CNT_W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin CPU/DMA bus arbiter with programmable wait states, burst lock
// and a mandatory dead cycle between owners; all bus outputs come from flops.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic              cp,
    input  logic              n_mr,
    mem_bus_arbiter_if.slave  bus
);

    state_t           state, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             pick;
    logic             ack_next;
    logic             cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0] cnt;

    ws_counter #(.CNT_W(CNT_W), .LOAD_VAL(WAIT_STATES)) u_ws_counter (
        .cp    (cp),
        .n_mr  (n_mr),
        .load  (cnt_load),
        .en    (cnt_en),
        .value (cnt),
        .zero  (cnt_zero)
    );

    // last_q resets to DMA so the CPU wins the first tie.
    always_ff @(posedge cp or negedge n_mr) begin
        if (!n_mr) begin
            state   <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Arbitration, access sequencing and next-cycle output decode.
    always_comb begin
        state_d  = state;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        pick     = 1'(REQ_CPU);
        ack_next = 1'b0;

        case (state)
            ST_IDLE, ST_TURN: begin
                if (bus.req == 2'b11) begin
                    pick = ~last_q;
                end else begin
                    pick = bus.req[REQ_DMA];
                end
                if (bus.req != 2'b00) begin
                    state_d  = ST_GRANT;
                    owner_d  = pick;
                    last_d   = pick;
                    cnt_load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!bus.req[owner_q]) begin
                    state_d = ST_TURN;
                end else if (cnt_zero) begin
                    // Ack cycle: a held lock restarts the access without a dead cycle.
                    if (bus.lock[owner_q]) begin
                        cnt_load = 1'b1;
                    end else begin
                        state_d = ST_TURN;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cnt_load) begin
            ack_next = (WAIT_STATES == 0);
        end else begin
            ack_next = cnt_en && (cnt == CNT_W'(1));
        end

        busy_d = (state_d == ST_GRANT);
        gnt_d  = busy_d ? sel_onehot(owner_d) : '0;
        ack_d  = (busy_d && ack_next) ? gnt_d : '0;
    end

    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and random checks of mem_bus_arbiter (WAIT_STATES=2 and 0 builds)
// against an access-level reference model.
module tb_mem_bus_arbiter;

    logic       cp = 1'b0;
    logic       n_mr;
    logic [1:0] req;
    logic [1:0] lock;

    mem_bus_arbiter_if bus0 ();
    mem_bus_arbiter_if bus1 ();

    assign bus0.req  = req;
    assign bus0.lock = lock;
    assign bus1.req  = req;
    assign bus1.lock = lock;

    mem_bus_arbiter #(.WAIT_STATES(2), .CNT_W(4)) dut0 (.cp(cp), .n_mr(n_mr), .bus(bus0));
    mem_bus_arbiter #(.WAIT_STATES(0), .CNT_W(4)) dut1 (.cp(cp), .n_mr(n_mr), .bus(bus1));

    always #5 cp = ~cp;

    int tests = 0;
    int fails = 0;

    // Model: owner (-1 = nobody granted), cycles left before the ack cycle, last winner.
    int         ws[2] = '{2, 0};
    int         m_own[2];
    int         m_left[2];
    int         m_last[2];
    logic [1:0] prev_g[2];

    logic [1:0] dg[2];
    logic [1:0] da[2];
    logic       db[2];
    logic       dow[2];

    assign dg[0]  = bus0.gnt;
    assign da[0]  = bus0.ack;
    assign db[0]  = bus0.busy;
    assign dow[0] = bus0.owner;
    assign dg[1]  = bus1.gnt;
    assign da[1]  = bus1.ack;
    assign db[1]  = bus1.busy;
    assign dow[1] = bus1.owner;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_own[d]  = -1;
            m_left[d] = 0;
            m_last[d] = 1;
            prev_g[d] = 2'b00;
        end
    endtask

    task automatic model_step();
        if (!n_mr) return;
        for (int d = 0; d < 2; d++) begin
            int o;
            int p;
            o = m_own[d];
            if (o < 0) begin
                if (req != 2'b00) begin
                    if (req == 2'b11) p = 1 - m_last[d];
                    else              p = req[1] ? 1 : 0;
                    m_own[d]  = p;
                    m_left[d] = ws[d];
                    m_last[d] = p;
                end
            end else if (!req[o]) begin
                m_own[d] = -1;
            end else if (m_left[d] == 0) begin
                if (lock[o]) m_left[d] = ws[d];
                else         m_own[d]  = -1;
            end else begin
                m_left[d] = m_left[d] - 1;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic [1:0] eg;
            logic [1:0] ea;
            eg = (m_own[d] < 0) ? 2'b00 : ((m_own[d] == 1) ? 2'b10 : 2'b01);
            ea = (m_own[d] >= 0 && m_left[d] == 0) ? eg : 2'b00;
            chk($sformatf("gnt[%0d]", d), 8'(dg[d]), 8'(eg));
            chk($sformatf("ack[%0d]", d), 8'(da[d]), 8'(ea));
            chk($sformatf("busy[%0d]", d), 8'(db[d]), 8'(eg != 2'b00));
            if (eg != 2'b00) chk($sformatf("owner[%0d]", d), 8'(dow[d]), 8'(m_own[d]));
            chk($sformatf("inv_not_both[%0d]", d), 8'(dg[d] != 2'b11), 8'd1);
            chk($sformatf("inv_ack_gnt[%0d]", d), 8'(da[d] == 2'b00 || da[d] == dg[d]), 8'd1);
            chk($sformatf("inv_dead_cycle[%0d]", d),
                8'(!(prev_g[d] != 2'b00 && dg[d] != 2'b00 && dg[d] != prev_g[d])), 8'd1);
            prev_g[d] = dg[d];
        end
    endtask

    task automatic tick();
        @(posedge cp);
        model_step();
        #1;
        check_all();
    endtask

    // Assert reset between edges, hold it for n edges, release just after an edge.
    task automatic do_reset(input int n);
        #2;
        n_mr = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_owner0", 8'(dow[0]), 8'd0);
        chk("rst_owner1", 8'(dow[1]), 8'd0);
        repeat (n) tick();
        n_mr = 1'b1;
    endtask

    logic [1:0] seq_g[9] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    logic [1:0] seq_a[9] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};

    initial begin
        n_mr = 1'b1;
        req  = 2'b00;
        lock = 2'b00;
        model_reset();
        #2;

        // Reset held with both requests pending, then CPU access.
        n_mr = 1'b0;
        req  = 2'b11;
        model_reset();
        #1;
        check_all();
        repeat (3) begin
            tick();
            chk("rst_gnt", 8'(dg[0]), 8'h00);
            chk("rst_ack", 8'(da[0]), 8'h00);
            chk("rst_busy", 8'(db[0]), 8'h00);
        end
        n_mr = 1'b1;
        req  = 2'b01;
        tick();
        chk("t1_gnt_first_edge", 8'(dg[0]), 8'h01);
        tick();
        chk("t1_ack_early", 8'(da[0]), 8'h00);
        tick();
        chk("t1_ack", 8'(da[0]), 8'h01);

        // Tie and round-robin.
        req = 2'b11;
        do_reset(1);
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("t2_gnt_c%0d", k + 1), 8'(dg[0]), 8'(seq_g[k]));
            chk($sformatf("t2_ack_c%0d", k + 1), 8'(da[0]), 8'(seq_a[k]));
        end

        // Burst of three locked CPU accesses while DMA waits.
        req  = 2'b11;
        lock = 2'b01;
        do_reset(1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("t3_gnt_c%0d", k), 8'(dg[0]), 8'h01);
            chk($sformatf("t3_ack_c%0d", k), 8'(da[0]), (k % 3 == 0) ? 8'h01 : 8'h00);
            if (k == 8) lock = 2'b00;
        end
        tick();
        chk("t3_turn", 8'(dg[0]), 8'h00);
        tick();
        chk("t3_dma", 8'(dg[0]), 8'h02);

        // DMA abort in its second grant cycle.
        req  = 2'b10;
        lock = 2'b00;
        do_reset(1);
        tick();
        chk("t4_gnt_c1", 8'(dg[0]), 8'h02);
        tick();
        chk("t4_gnt_c2", 8'(dg[0]), 8'h02);
        req = 2'b00;
        tick();
        chk("t4_turn", 8'(dg[0]), 8'h00);
        chk("t4_no_ack", 8'(da[0]), 8'h00);
        tick();
        chk("t4_idle_ack", 8'(da[0]), 8'h00);

        // Asynchronous reset in the middle of a CPU access.
        req = 2'b01;
        do_reset(1);
        tick();
        tick();
        chk("t5_pre_gnt", 8'(dg[0]), 8'h01);
        #3;
        n_mr = 1'b0;
        model_reset();
        #1;
        chk("t5_async_gnt", 8'(dg[0]), 8'h00);
        chk("t5_async_busy", 8'(db[0]), 8'h00);
        check_all();
        req = 2'b11;
        tick();
        n_mr = 1'b1;
        tick();
        chk("t5_cpu_wins", 8'(dg[0]), 8'h01);

        // Zero wait states: grant and ack in one cycle.
        req = 2'b10;
        do_reset(1);
        tick();
        chk("t6_gnt", 8'(dg[1]), 8'h02);
        chk("t6_ack", 8'(da[1]), 8'h02);
        req = 2'b00;
        tick();
        chk("t6_turn", 8'(dg[1]), 8'h00);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            req  = 2'($urandom_range(0, 3));
            lock = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) do_reset(int'($urandom_range(0, 2)));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
